lfsr_decrypt_engine: RTL and testbench

LFSR_DECRYPT_ENGINE -- requirements
Module: lfsr_decrypt_engine

---
 rtl/lfsr_pkg.sv | 11 +
 rtl/lfsr_step.sv | 8 +
 rtl/lfsr_decrypt_engine.sv | 152 +++++++++++++++
 tb/tb_lfsr_decrypt_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: tap table, space constant, FSM states and default addressing
// shared by the LFSR decrypt engine and its step function.
package lfsr_pkg;
    localparam logic [7:0]      SPACE = 8'h20;
    localparam logic [7:0][7:0] TAPS  = {8'hf3, 8'hfa, 8'hb2, 8'hb4, 8'hb8, 8'hc6, 8'hd4, 8'he1};
    localparam int DEF_MSG_BASE = 64;
    localparam int DEF_MSG_LEN  = 64;
    localparam int DEF_OUT_LEN  = 41;
    localparam int DEF_PRE_MIN  = 9;
    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECRYPT, PAD, DONE} state_t;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one Fibonacci-style shift, new LSB is the parity of the tapped bits.
module lfsr_step (
    input  logic [7:0] s_i,
    input  logic [7:0] taps_i,
    output logic [7:0] next_o
);
    assign next_o = {s_i[6:0], ^(s_i & taps_i)};
endmodule

// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine: recovers seed and taps from a space preamble, then decrypts,
// strips leading spaces and writes OUT_LEN bytes from address 0. LFSR_DEC_ERR_EN adds err.
module lfsr_decrypt_engine
    import lfsr_pkg::*;
#(
    parameter int MSG_BASE = DEF_MSG_BASE,
    parameter int MSG_LEN  = DEF_MSG_LEN,
    parameter int OUT_LEN  = DEF_OUT_LEN,
    parameter int PRE_MIN  = DEF_PRE_MIN
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic [2:0] tap_idx
`ifdef LFSR_DEC_ERR_EN
    ,
    output logic       err
`endif
);
    localparam logic [7:0] BASE  = 8'(MSG_BASE);
    localparam logic [7:0] KLAST = 8'(MSG_LEN - 1);
    localparam logic [7:0] OLEN  = 8'(OUT_LEN);
    localparam logic [7:0] PLAST = 8'(PRE_MIN);

    if (MSG_BASE + MSG_LEN - 1 > 255 || PRE_MIN < 9) begin : g_bad_cfg
        $error("lfsr_decrypt_engine: message must end at or below 255 and the preamble must cover 9 bytes");
    end

    state_t          state_q;
    logic [8:0][7:0] pre_q;
    logic [7:0]      cnt_q, k_q, out_ptr_q, lfsr_q, lfsr_d, ptr_d, seed, plain;
    logic [2:0]      cand_q, tap_q;
    logic            ph_q, seen_q, done_q, keep, dec_wr, match;
    logic [7:0]      hit;
`ifdef LFSR_DEC_ERR_EN
    logic            err_q;
    assign err = err_q;
`endif

    // Candidate taps replay s_1..s_8 from the seed and must reproduce the whole preamble.
    assign seed = pre_q[0] ^ SPACE;
    for (genvar i = 0; i < 8; i++) begin : g_s
        logic [7:0] prev, nxt;
        if (i == 0) begin : g_first
            assign prev = seed;
        end else begin : g_next
            assign prev = g_s[i-1].nxt;
        end
        lfsr_step u_step (.s_i(prev), .taps_i(TAPS[cand_q]), .next_o(nxt));
        assign hit[i] = nxt == (pre_q[i+1] ^ SPACE);
    end
    assign match = &hit;

    lfsr_step u_dec (.s_i(lfsr_q), .taps_i(TAPS[tap_q]), .next_o(lfsr_d));

    assign plain     = mem_rdata ^ lfsr_q;
    assign keep      = seen_q || plain != SPACE;
    assign dec_wr    = state_q == DECRYPT && ph_q && keep && out_ptr_q < OLEN;
    assign mem_we    = dec_wr || state_q == PAD;
    assign mem_wdata = state_q == PAD ? SPACE : dec_wr ? plain : 8'h00;
    assign mem_addr  = state_q == LOAD    ? BASE + cnt_q
                     : state_q == DECRYPT ? (ph_q ? out_ptr_q : BASE + k_q)
                     : state_q == PAD     ? out_ptr_q : 8'h00;
    assign ptr_d     = out_ptr_q + 8'(mem_we);
    assign done      = done_q;
    assign tap_idx   = tap_q;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            out_ptr_q <= '0;
            lfsr_q    <= '0;
            cand_q    <= '0;
            tap_q     <= '0;
            ph_q      <= 1'b0;
            seen_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LFSR_DEC_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q   <= LOAD;
                    cnt_q     <= '0;
                    k_q       <= '0;
                    out_ptr_q <= '0;
                    cand_q    <= '0;
                    ph_q      <= 1'b0;
                    seen_q    <= 1'b0;
                    done_q    <= 1'b0;
`ifdef LFSR_DEC_ERR_EN
                    err_q     <= 1'b0;
`endif
                end
                LOAD: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q != 8'd0 && cnt_q <= 8'd9) pre_q <= {mem_rdata, pre_q[8:1]};
                    if (cnt_q == PLAST) state_q <= SEARCH;
                end
                SEARCH: if (match || cand_q == 3'd7) begin
`ifdef LFSR_DEC_ERR_EN
                    if (match) begin
                        tap_q   <= cand_q;
                        lfsr_q  <= seed;
                        state_q <= DECRYPT;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
`else
                    tap_q   <= match ? cand_q : 3'd0;
                    lfsr_q  <= seed;
                    state_q <= DECRYPT;
`endif
                end else begin
                    cand_q <= cand_q + 3'd1;
                end
                DECRYPT: begin
                    ph_q <= !ph_q;
                    if (ph_q) begin
                        lfsr_q    <= lfsr_d;
                        seen_q    <= keep;
                        out_ptr_q <= ptr_d;
                        k_q       <= k_q + 8'd1;
                        if (k_q == KLAST) begin
                            state_q <= ptr_d < OLEN ? PAD : DONE;
                            done_q  <= ptr_d >= OLEN;
                        end
                    end
                end
                PAD: begin
                    out_ptr_q <= ptr_d;
                    if (ptr_d == OLEN) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// tb_lfsr_decrypt_engine: encrypts directed messages into a bench memory and
// scoreboards every write of the engine against hand-written plaintext.
module tb_lfsr_decrypt_engine;
    import lfsr_pkg::*;

    localparam logic [7:0] TB_TAPS [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0, init_n = 1'b0, start = 1'b0;
    logic       done, mem_we;
    logic [7:0] mem_addr, mem_rdata, mem_wdata, rd;
    logic [2:0] tap_idx;
`ifdef LFSR_DEC_ERR_EN
    logic       err;
`endif

    lfsr_decrypt_engine dut (
        .clk(clk), .init_n(init_n), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .tap_idx(tap_idx)
`ifdef LFSR_DEC_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        rd = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= rd;
    end

    int  n_chk = 0, n_fail = 0, search_cnt = 0, done_rises = 0, wr_cnt = 0;
    bit  done_prev = 1'b0, sb_off = 1'b0;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dut.state_q == SEARCH) search_cnt++;
        if (done && !done_prev) done_rises++;
        done_prev = done;
        if (init_n && mem_we) begin
            wr_cnt++;
            if (!sb_off) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %h, no write expected", mem_addr, mem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("write[%0d]", mon_e.a), {mem_addr, mem_wdata}, {mon_e.a, mon_e.d});
                end
            end
        end
    end

    function automatic logic [7:0] step(logic [7:0] s, logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction

    function automatic int first_hit(logic [7:0] seed, int ti);
        logic [7:0] r [9];
        logic [7:0] s;
        bit ok;
        r[0] = seed;
        for (int i = 1; i < 9; i++) r[i] = step(r[i-1], TB_TAPS[ti]);
        for (int c = 0; c < 8; c++) begin
            s  = seed;
            ok = 1'b1;
            for (int i = 1; i < 9; i++) begin
                s = step(s, TB_TAPS[c]);
                if (s != r[i]) ok = 1'b0;
            end
            if (ok) return c;
        end
        return -1;
    endfunction

    // Walk from the preferred seed to one whose preamble identifies only the intended taps.
    function automatic logic [7:0] pick_seed(logic [7:0] pref, int ti);
        logic [7:0] sd;
        for (int n = 0; n < 256; n++) begin
            sd = pref + 8'(n);
            if (sd != 8'h00 && first_hit(sd, ti) == ti) return sd;
        end
        return pref;
    endfunction

    function automatic string spaces(int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    task automatic prep(int pre, string txt, int ti, logic [7:0] seed, string exp_s);
        logic [7:0] s, p;
        s = seed;
        exp_q.delete();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int k = 0; k < 64; k++) begin
            p = (k >= pre && k - pre < txt.len()) ? 8'(txt[k-pre]) : 8'h20;
            mem[64+k] = p ^ s;
            s = step(s, TB_TAPS[ti]);
        end
        for (int i = 0; i < exp_s.len(); i++) exp_q.push_back('{a: 8'(i), d: 8'(exp_s[i])});
    endtask

    task automatic go();
        search_cnt = 0;
        done_rises = 0;
        wr_cnt     = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("done_cleared_on_start", done, 0);
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done"}, done, 1);
        @(negedge clk);
        #1;
        check({nm, "_writes_pending"}, exp_q.size(), 0);
        check({nm, "_done_once"}, done_rises, 1);
    endtask

    string t1 = "Knowledge comes, but wisdom lingers.     ";
    string t2 = "  f       A joke is a very serious thing.";
    string e2 = "f       A joke is a very serious thing.  ";
    string t4 = "Patience is bitter but its fruit is sweet.";
    string e4 = "Patience is bitter but its fruit is sweet";

    initial begin
        int  n;
        bit  found;
        logic [7:0] s1;
        s1 = pick_seed(8'h25, 4);
        #1;
        check("reset_done", done, 0);
        check("reset_we", mem_we, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_tap", tap_idx, 0);
        #11 init_n = 1'b1;

        prep(9, t1, 4, s1, t1);
        go();
        wait_done("wisdom");
        check("wisdom_tap", tap_idx, 4);

        prep(10, t2, 6, pick_seed(8'h5a, 6), e2);
        go();
        wait_done("joke");
        check("joke_tap", tap_idx, 6);

        prep(9, {spaces(46), "Tail text"}, 0, pick_seed(8'h3c, 0), {"Tail text", spaces(32)});
        go();
        wait_done("tail_e1");
        check("tail_e1_tap", tap_idx, 0);
        check("tail_e1_search_cycles", search_cnt, 1);

        prep(9, t4, 7, pick_seed(8'h77, 7), e4);
        go();
        n = 0;
        while (dut.state_q != SEARCH && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("f3_reached_search", dut.state_q == SEARCH, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("f3");
        check("f3_tap", tap_idx, 7);
        check("f3_search_cycles", search_cnt, 8);

        prep(9, t1, 4, s1, t1);
        go();
        n = 0;
        found = 1'b0;
        while (n < 400 && !found) begin
            @(posedge clk);
            #2;
            found = dut.out_ptr_q == 8'd12 && mem_we;
            n++;
        end
        check("abort_reached_ptr12", found, 1);
        init_n = 1'b0;
        #1;
        check("abort_we_low", mem_we, 0);
        check("abort_state_idle", dut.state_q == IDLE, 1);
        check("abort_done_low", done, 0);
        repeat (3) @(posedge clk);
        check("abort_no_write12", mem[12], 0);
        #3 init_n = 1'b1;
        prep(9, t1, 4, s1, t1);
        go();
        wait_done("restart");
        check("restart_tap", tap_idx, 4);

        prep(9, t1, 4, s1, "");
        mem[64+5] = mem[64+5] ^ 8'hff;
`ifdef LFSR_DEC_ERR_EN
        go();
        wait_done("nomatch");
        check("nomatch_err", err, 1);
        check("nomatch_writes", wr_cnt, 0);
`else
        sb_off = 1'b1;
        go();
        wait_done("nomatch");
        sb_off = 1'b0;
        check("nomatch_tap", tap_idx, 0);
        check("nomatch_writes", wr_cnt, 41);
`endif

        prep(9, "", 2, pick_seed(8'h91, 2), spaces(41));
        go();
`ifdef LFSR_DEC_ERR_EN
        check("err_cleared_on_start", err, 0);
`endif
        wait_done("all_space");
        check("all_space_tap", tap_idx, 2);
        check("all_space_writes", wr_cnt, 41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
